// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared types and constants for the UART transmit scheduler.
//                byte_t        - one transmit byte
//                sched_state_t - scheduler FSM states
//                grant_t       - identity of the last granted requester
//                WORD_BYTES    - bytes per requester-B word
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        DRAIN_B = 1'b1
    } sched_state_t;

    typedef enum logic [0:0] {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    localparam int WORD_BYTES = 4;

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Circular byte FIFO, 2**DEPTH_LOG entries, one push and one
//                pop per cycle (both allowed together). The head byte is read
//                combinationally from registered state, so a pushed byte is
//                first visible on the cycle after the push.
//  Ports       : clk, rst       - clock, asynchronous active-high reset
//                push, push_data - write one byte (caller guarantees room)
//                pop            - remove head byte (caller guarantees data)
//                head_data      - byte at the read pointer
//                count          - bytes held, 0..2**DEPTH_LOG
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  byte_t                push_data,
    input  logic                 pop,
    output byte_t                head_data,
    output logic [DEPTH_LOG:0]   count
);

    localparam int DEPTH = 2 ** DEPTH_LOG;

    byte_t                 mem_q [DEPTH];
    logic [DEPTH_LOG-1:0]  wr_ptr_q;
    logic [DEPTH_LOG-1:0]  rd_ptr_q;
    logic [DEPTH_LOG:0]    count_q;
    logic [DEPTH_LOG:0]    count_d;

    // Count is tracked separately so full and empty are unambiguous while
    // the narrower pointers simply wrap.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG+1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule : byte_fifo
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART transmitter between requester A (single
//                bytes) and requester B (32-bit words sent MSB first as four
//                uninterrupted bytes). Round-robin arbitration on ties, bytes
//                buffered in a byte FIFO feeding the transmitter handshake.
//  Ports       : CLK, RST             - clock, asynchronous active-high reset
//                a_data/a_valid/a_ready - requester A byte handshake
//                b_data/b_valid/b_ready - requester B word handshake
//                tx_data/tx_valid/tx_ready - transmitter byte handshake
//                fifo_count           - bytes buffered
//                busy                 - draining a word or FIFO non-empty
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_tx_pkg::*;
#(
    parameter int DEPTH_LOG = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [7:0]           a_data,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [31:0]          b_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [DEPTH_LOG:0]   fifo_count,
    output logic                 busy
);

    localparam logic [DEPTH_LOG:0] c_DEPTH      = (DEPTH_LOG+1)'(2 ** DEPTH_LOG);
    localparam logic [DEPTH_LOG:0] c_WORD_BYTES = (DEPTH_LOG+1)'(WORD_BYTES);

    sched_state_t        state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [23:0]         word_q, word_d;   // MSB byte is pushed at accept
    grant_t              last_q, last_d;

    logic                w_push;
    byte_t               w_push_data;
    logic                w_pop;
    logic [DEPTH_LOG:0]  w_free;
    logic                w_idle;
    logic                w_elig_a;
    logic                w_elig_b;
    logic                w_a_fire;
    logic                w_b_fire;

    // Eligibility uses the registered count only; a same-cycle pop never
    // creates room.
    assign w_free   = c_DEPTH - fifo_count;
    assign w_idle   = (state_q == IDLE);
    assign w_elig_a = w_idle && (w_free >= (DEPTH_LOG+1)'(1));
    assign w_elig_b = w_idle && (w_free >= c_WORD_BYTES);

    // Each ready yields only when the other side is contending and it was
    // not granted last, so at most one handshake fires per cycle and
    // neither ready depends on its own valid.
    assign a_ready  = w_elig_a && !(b_valid && w_elig_b && (last_q == GRANT_A));
    assign b_ready  = w_elig_b && !(a_valid && w_elig_a && (last_q == GRANT_B));
    assign w_a_fire = a_valid && a_ready;
    assign w_b_fire = b_valid && b_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            word_q  <= '0;
            last_q  <= GRANT_B;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        word_d      = word_q;
        last_d      = last_q;
        w_push      = 1'b0;
        w_push_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (w_a_fire) begin
                    w_push      = 1'b1;
                    w_push_data = a_data;
                    last_d      = GRANT_A;
                end else if (w_b_fire) begin
                    w_push      = 1'b1;
                    w_push_data = b_data[31:24];
                    word_d      = b_data[23:0];
                    k_d         = 2'd2;
                    last_d      = GRANT_B;
                    state_d     = DRAIN_B;
                end
            end
            DRAIN_B: begin
                w_push = 1'b1;
                case (k_q)
                    2'd2:    w_push_data = word_q[23:16];
                    2'd1:    w_push_data = word_q[15:8];
                    default: w_push_data = word_q[7:0];
                endcase
                if (k_q == 2'd0) state_d = IDLE;
                else             k_d     = k_q - 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_pop = tx_valid && tx_ready;

    byte_fifo #(
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head_data (tx_data),
        .count     (fifo_count)
    );

    assign tx_valid = (fifo_count != '0);
    assign busy     = !w_idle || (fifo_count != '0);

endmodule : uart_tx_scheduler
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_scheduler
//  Description : Self-checking bench for uart_tx_scheduler. A queue-based
//                reference model predicts every output each cycle; directed
//                phases add fixed expected sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    localparam int DEPTH_LOG = 3;
    localparam int DEPTH     = 2 ** DEPTH_LOG;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b0;
    logic [7:0]           a_data = 8'h00;
    logic                 a_valid = 1'b0;
    logic                 a_ready;
    logic [31:0]          b_data = 32'h0;
    logic                 b_valid = 1'b0;
    logic                 b_ready;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready = 1'b0;
    logic [DEPTH_LOG:0]   fifo_count;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bytes in the FIFO, bytes of a word still to push,
    // and who was granted last (0 = A, 1 = B).
    logic [7:0] m_q[$];
    logic [7:0] m_pend[$];
    bit         m_last = 1'b1;

    always #5 CLK = ~CLK;

    uart_tx_scheduler #(.DEPTH_LOG(DEPTH_LOG)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .a_data     (a_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_data     (b_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entered just after a rising edge. Returns just after the next one.
    task automatic do_reset();
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        tx_ready = 1'b0;
        RST      = 1'b1;
        #4;
        m_q.delete();
        m_pend.delete();
        m_last = 1'b1;
        check("rst_cnt_async", 32'(fifo_count), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_count",    32'(fifo_count), 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_a_ready",  32'(a_ready), 32'd1);
        check("rst_b_ready",  32'(b_ready), 32'd1);
        @(posedge CLK);
        #1;
    endtask

    // One clock: drive inputs, compare all outputs to the model, then
    // advance the model by the same edge.
    task automatic cycle(input bit av, input logic [7:0] ad, input bit bv,
                         input logic [31:0] bd, input bit tr);
        int n;
        bit idle, ea, eb, ar, br;
        a_valid  = av;
        a_data   = ad;
        b_valid  = bv;
        b_data   = bd;
        tx_ready = tr;
        #2;
        n    = m_q.size();
        idle = (m_pend.size() == 0);
        ea   = idle && (n < DEPTH);
        eb   = idle && ((DEPTH - n) >= 4);
        ar   = ea && !(bv && eb && (m_last == 1'b0));
        br   = eb && !(av && ea && (m_last == 1'b1));
        check("a_ready",    32'(a_ready), 32'(ar));
        check("b_ready",    32'(b_ready), 32'(br));
        check("tx_valid",   32'(tx_valid), 32'(n != 0));
        check("fifo_count", 32'(fifo_count), 32'(n));
        check("busy",       32'(busy), 32'((n != 0) || !idle));
        if (n != 0) check("tx_data", 32'(tx_data), 32'(m_q[0]));
        if (n != 0 && tr) void'(m_q.pop_front());
        if (!idle) begin
            m_q.push_back(m_pend.pop_front());
        end else if (av && ar) begin
            m_q.push_back(ad);
            m_last = 1'b0;
        end else if (bv && br) begin
            m_q.push_back(bd[31:24]);
            m_pend.push_back(bd[23:16]);
            m_pend.push_back(bd[15:8]);
            m_pend.push_back(bd[7:0]);
            m_last = 1'b1;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] beef[4];
        logic [7:0] tie[5];
        beef = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        tie  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        @(posedge CLK);
        #1;
        do_reset();

        // Single A byte visible the next cycle, then drained.
        cycle(1'b1, 8'h41, 1'b0, 32'h0, 1'b1);
        check("a_byte_data", 32'(tx_data), 32'h41);
        check("a_byte_valid", 32'(tx_valid), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
        check("a_byte_empty", 32'(fifo_count), 32'd0);

        // B word with the transmitter stalled, A contending during the drain.
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h77, 1'b0, 32'h0, 1'b0);
        check("beef_count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("beef_seq", 32'(tx_data), 32'(beef[i]));
            cycle(1'b0, 8'h00, 1'b0, 32'h0, 1'b1);
        end

        // Tie from reset: A first, then whole words alternating with A.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(1'b1, 8'h11, 1'b1, 32'h22334455, 1'b1);
            check("tie_seq", 32'(tx_data), 32'(tie[i % 5]));
        end

        // Randomized traffic with occasional resets, some mid-drain.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
                  1'($urandom_range(0, 3) == 0), $urandom,
                  1'($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx_scheduler
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter between two requesters:
  - port A: core I/O output, one byte per request.
  - port B: debug/monitor dump, one 32-bit word per request, sent as 4 bytes MSB first, never interleaved with A bytes.
- Arbitrates round-robin and buffers accepted bytes in a byte FIFO.
- Drives the transmitter through its valid/ready byte handshake; sits between the core/debug logic and the UART transmitter.

Parameters:
- DEPTH_LOG, 4, log2 of FIFO depth in bytes; legal range >= 2, so depth is at least 4.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- a_data  input  8  byte from requester A.
- a_valid  input  1  A has a byte.
- a_ready  output  1  A byte is accepted this cycle when a_valid && a_ready.
- b_data  input  32  word from requester B.
- b_valid  input  1  B has a word.
- b_ready  output  1  B word is accepted this cycle when b_valid && b_ready.
- tx_data  output  8  byte to the transmitter.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  transmitter idle; a pop occurs when tx_valid && tx_ready.
- fifo_count  output  DEPTH_LOG+1  bytes currently held (0..2**DEPTH_LOG).
- busy  output  1  (state != IDLE) || (fifo_count != 0).

Behaviour:
- Clock/reset: one clock CLK; RST asynchronous, active-high.
- Reset values:
  - pointers = 0, fifo_count = 0, state = IDLE, last_grant = B (so A wins the first tie).
  - tx_valid = 0, a_ready = 1, b_ready = 1 (DEPTH >= 4), busy = 0.
- Reset mid-drain: latched word bytes not yet pushed are discarded. FIFO contents are discarded.
- FIFO:
  - Circular, 2**DEPTH_LOG bytes, at most 1 push and 1 pop per cycle.
  - Simultaneous push and pop is allowed; count is unchanged.
  - free = 2**DEPTH_LOG - fifo_count.
- tx side:
  - tx_valid = (fifo_count != 0); tx_data = mem[rd_ptr], combinational from registered state.
  - No bypass: a byte pushed in cycle N is first visible on tx_valid/tx_data in cycle N+1.
- States: IDLE, DRAIN_B.
  - DRAIN_B carries a 2-bit index k, counting down 2, 1, 0.
- Eligibility, using registered count only; a same-cycle pop never makes room:
  - elig_a = IDLE && free >= 1.
  - elig_b = IDLE && free >= 4.
- Ready generation (ready never depends on its own valid):
  - a_ready = elig_a && !(b_valid && elig_b && last_grant == A).
  - b_ready = elig_b && !(a_valid && elig_a && last_grant == B).
  - Only one of the two handshakes can fire in a cycle.
- A accept:
  - Push a_data on that edge; last_grant <= A.
- B accept:
  - Latch b_data and push b_data[31:24] on that edge.
  - state <= DRAIN_B, k <= 2, last_grant <= B.
- DRAIN_B:
  - Each cycle, push latched byte k (bits 8k+7:8k).
  - At k == 0, return to IDLE.
  - a_ready = b_ready = 0 throughout.
  - The 4 pushes occupy exactly 4 consecutive cycles.
  - The free >= 4 check at accept guarantees no overflow; pops only add room.
- Full FIFO: a_ready = 0 even if a pop occurs that cycle. Empty FIFO: tx_valid = 0.
- Starvation rule: B may wait while free < 4 and A keeps filling the FIFO. This is accepted; tie-break fairness applies only when both are eligible.
- Pointer wrap: pointers are DEPTH_LOG bits and wrap naturally. Count is tracked separately and is DEPTH_LOG+1 bits wide.

Decomposition:
- Package uart_tx_pkg:
  - typedef byte_t (logic[7:0]).
  - enum sched_state_t {IDLE, DRAIN_B}.
  - enum grant_t {GRANT_A, GRANT_B}.
  - localparam WORD_BYTES = 4.
- Sub-module byte_fifo (parameter DEPTH_LOG):
  - Ports: push, push_data, pop, head_data, count.
  - Async-reset pointers.
- The scheduler contains the arbiter and the B drain FSM only.

Test Plan:
- Reset then idle: RST pulsed mid-operation -> tx_valid = 0, fifo_count = 0, busy = 0, a_ready = b_ready = 1 on the cycle after release.
- A single byte: a_data = 8'h41 accepted in cycle N, tx_ready = 1 -> tx_valid = 1, tx_data = 8'h41 in cycle N+1; pop at N+1; fifo_count back to 0 at N+2.
- B word: b_data = 32'hDEADBEEF, tx_ready = 0 -> fifo_count reaches 4 after 4 cycles. With tx_ready then held at 1, tx_data sequence is DE, AD, BE, EF. a_ready = 0 during cycles N+1..N+3.
- Tie: a_valid and b_valid held from reset with empty FIFO, A byte 8'h11, B word 32'h22334455 -> FIFO order is 11, 22, 33, 44, 55, 11, 22, ...; no A byte lands between bytes of one word.
- Full/boundary (DEPTH_LOG = 2, tx_ready = 0):
  - Fill 3 A bytes -> b_ready = 0.
  - Add a 4th byte -> a_ready = 0.
  - Pulse tx_ready for one cycle -> one pop, a_ready = 1 only on the next cycle.
- Simultaneous push/pop: fifo_count = 2, A accepted while popping -> fifo_count stays 2, byte order preserved.
